risc5_mem_arbiter: RTL

//  Shares one single-port 32-bit SRAM between the RISC5 core and the video refresh engine.

---
 rtl/risc5_mem_arbiter_pkg.sv | 30 +++
 rtl/risc5_mem_arbiter_mem_access_timer.sv | 31 +++
 rtl/risc5_mem_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/risc5_mem_arbiter_pkg.sv
// Shared definitions for the RISC5 SRAM arbiter: FSM state codes,
// default geometry and the byte-enable helper.
package risc5_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_VID  = 2'd2
  } state_t;

  localparam int DEF_AW      = 18;
  localparam int DEF_ACC_CYC = 2;
  localparam int DEF_BURST   = 8;

  // Access timer width covers ACC_CYC up to 15; burst counter covers BURST up to 64.
  localparam int CNT_W  = 4;
  localparam int BCNT_W = 6;

  // SRAM byte enables: only a byte store narrows the lanes, everything else is a full word.
  function automatic logic [3:0] lane_be(input logic wr, input logic ben, input logic [1:0] lane);
    logic [3:0] be;
    if (wr && ben) begin
      be = 4'b0001 << lane;
    end else begin
      be = 4'hF;
    end
    return be;
  endfunction

endpackage

// File: rtl/risc5_mem_arbiter_mem_access_timer.sv
// Per-word SRAM access timer: counts 0..ACC_CYC-1 while an access is running
// and flags the final cycle, where read data is captured and the next word begins.
module mem_access_timer
  import risc5_mem_arbiter_pkg::*;
#(
  parameter int ACC_CYC = DEF_ACC_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [CNT_W-1:0] wcnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] WLAST = CNT_W'(ACC_CYC - 1);
  localparam logic [CNT_W-1:0] WONE  = CNT_W'(1);

  assign last = run && (wcnt == WLAST);

  // Advance within an access; restart at every access boundary or when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= {CNT_W{1'b0}};
    end else if (!run || last) begin
      wcnt <= {CNT_W{1'b0}};
    end else begin
      wcnt <= wcnt + WONE;
    end
  end

endmodule

// File: rtl/risc5_mem_arbiter.sv
// Arbiter sharing one single-port SRAM between the RISC5 core and the video
// refresh engine. Each idle cycle accepts one core access; a pending video
// request is granted a full burst first, then the held core access is served.
module risc5_mem_arbiter
  import risc5_mem_arbiter_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int ACC_CYC = DEF_ACC_CYC,
  parameter int BURST   = DEF_BURST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [23:0]   adr,
  input  logic          rd,
  input  logic          wr,
  input  logic          ben,
  input  logic [31:0]   outbus,
  output logic [31:0]   inbus,
  output logic          stallX,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_adr,
  output logic          vid_ack,
  output logic [31:0]   vid_data,
  output logic          vid_valid,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_adr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [BCNT_W-1:0] BLAST = BCNT_W'(BURST - 1);
  localparam logic [BCNT_W-1:0] BONE  = BCNT_W'(1);
  localparam logic [AW-1:0]     VONE  = AW'(1);

  state_t            state_r, state_nxt_s;
  logic              last_s;
  logic [CNT_W-1:0]  wcnt_s;
  logic [BCNT_W-1:0] bcnt_r;
  logic [AW-1:0]     vaddr_r;
  logic [AW-1:0]     vaddr_nxt_s;
  logic [3:0]        req_be_s;
  logic              pend_we_r;
  logic [3:0]        pend_be_r;
  logic [AW-1:0]     pend_adr_r;
  logic [31:0]       pend_wdata_r;
  logic              unused_s;

  // Loads and fetches are both plain reads, so rd and the high address bits carry no information here.
  assign unused_s    = ^{adr[23:AW+2], rd, wcnt_s};
  assign req_be_s    = lane_be(wr, ben, adr[1:0]);
  assign vaddr_nxt_s = vaddr_r + VONE;

  mem_access_timer #(.ACC_CYC(ACC_CYC)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (state_r != ST_IDLE),
    .wcnt (wcnt_s),
    .last (last_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: video wins an idle cycle, a burst always hands over to the held core access.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (vid_req) begin
          state_nxt_s = ST_VID;
        end else begin
          state_nxt_s = ST_CPU;
        end
      end
      ST_CPU: begin
        if (last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CPU;
        end
      end
      ST_VID: begin
        if (last_s && (bcnt_r == BLAST)) begin
          state_nxt_s = ST_CPU;
        end else begin
          state_nxt_s = ST_VID;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered SRAM pins, core stall/data and video outputs, sequenced per state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallX       <= 1'b0;
      inbus        <= 32'h0;
      vid_ack      <= 1'b0;
      vid_data     <= 32'h0;
      vid_valid    <= 1'b0;
      mem_cs       <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= 4'h0;
      mem_adr      <= {AW{1'b0}};
      mem_wdata    <= 32'h0;
      vaddr_r      <= {AW{1'b0}};
      bcnt_r       <= {BCNT_W{1'b0}};
      pend_we_r    <= 1'b0;
      pend_be_r    <= 4'h0;
      pend_adr_r   <= {AW{1'b0}};
      pend_wdata_r <= 32'h0;
    end else begin
      vid_ack   <= 1'b0;
      vid_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          pend_we_r    <= wr;
          pend_be_r    <= req_be_s;
          pend_adr_r   <= adr[AW+1:2];
          pend_wdata_r <= outbus;
          stallX       <= 1'b1;
          mem_cs       <= 1'b1;
          mem_wdata    <= outbus;
          if (vid_req) begin
            vid_ack <= 1'b1;
            vaddr_r <= vid_adr;
            bcnt_r  <= {BCNT_W{1'b0}};
            mem_adr <= vid_adr;
            mem_we  <= 1'b0;
            mem_be  <= 4'hF;
          end else begin
            mem_adr <= adr[AW+1:2];
            mem_we  <= wr;
            mem_be  <= req_be_s;
          end
        end
        ST_CPU: begin
          if (last_s) begin
            if (!pend_we_r) begin
              inbus <= mem_rdata;
            end
            stallX <= 1'b0;
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
          end
        end
        ST_VID: begin
          if (last_s) begin
            vid_data  <= mem_rdata;
            vid_valid <= 1'b1;
            if (bcnt_r == BLAST) begin
              bcnt_r    <= {BCNT_W{1'b0}};
              mem_adr   <= pend_adr_r;
              mem_we    <= pend_we_r;
              mem_be    <= pend_be_r;
              mem_wdata <= pend_wdata_r;
            end else begin
              bcnt_r  <= bcnt_r + BONE;
              vaddr_r <= vaddr_nxt_s;
              mem_adr <= vaddr_nxt_s;
            end
          end
        end
        default: begin
          stallX <= 1'b0;
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
